// File: rtl/core_inst_seq.sv
// Instruction sequencer for one kernel-position (kij) pass of the PE core:
// weight load, activation load, execute, then OFIFO drain into psum memory.
module core_inst_seq #(
    parameter int unsigned row       = 8,
    parameter int unsigned col       = 8,
    parameter int unsigned len_nij   = 36,
    parameter int unsigned len_kij   = 9,
    parameter logic [10:0] w_base    = 11'h400,
    parameter int unsigned drain_max = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  kij,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned M1      = (drain_max > len_nij + 1) ? drain_max : len_nij + 1;
    localparam int unsigned M2      = (M1 > col + 1) ? M1 : col + 1;
    localparam int unsigned CNT_MAX = (M2 > row) ? M2 : row;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RD_W    = $clog2(len_nij + 1);

    typedef struct packed {
        logic        acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    localparam inst_t INST_IDLE = inst_t'(34'h1_800C_0000);

    typedef enum logic [3:0] {
        S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_X_L0, S_EXEC, S_DRAIN, S_OFIFO, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       kij_q, kij_d;
    logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [RD_W-1:0]  wr_cnt_q, wr_cnt_d;
    inst_t            inst_q, inst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rd_d, wr_d;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            kij_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            inst_q   <= INST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kij_q    <= kij_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state, phase counter and OFIFO read/write bookkeeping
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        kij_d    = kij_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                rd_cnt_d = '0;
                wr_cnt_d = '0;
                if (start) begin
                    if (32'(kij) < len_kij) begin
                        kij_d   = kij;
                        state_d = S_W_L0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_W_L0: if (cnt_q == CNT_W'(col)) begin
                state_d = S_W_LOAD;
                cnt_d   = '0;
            end
            S_W_LOAD: if (cnt_q == CNT_W'(col - 1)) begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: if (cnt_q == CNT_W'(row - 1)) begin
                state_d = S_X_L0;
                cnt_d   = '0;
            end
            S_X_L0: if (cnt_q == CNT_W'(len_nij)) begin
                state_d = S_EXEC;
                cnt_d   = '0;
            end
            S_EXEC: if (cnt_q == CNT_W'(len_nij - 1)) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    state_d = S_OFIFO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(drain_max - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            S_OFIFO: begin
                cnt_d = '0;
                if (wr_cnt_q == RD_W'(len_nij)) begin
                    state_d = S_DONE;
                end else begin
                    // A read seen on inst this cycle becomes a pmem write next cycle
                    rd_d     = ofifo_valid && (rd_cnt_q < RD_W'(len_nij));
                    wr_d     = inst_q.ofifo_rd;
                    rd_cnt_d = rd_cnt_q + RD_W'(rd_d);
                    wr_cnt_d = wr_cnt_q + RD_W'(wr_d);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction word for the upcoming cycle, decoded from next state
    always_comb begin
        inst_d = INST_IDLE;
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        unique case (state_d)
            S_W_L0: begin
                if (cnt_d < CNT_W'(col)) begin
                    inst_d.cen_xmem = 1'b0;
                    inst_d.a_xmem   = w_base + 11'(kij_d) * 11'(col) + 11'(cnt_d);
                end
                inst_d.l0_wr = (cnt_d != '0);
            end
            S_W_LOAD: begin
                inst_d.l0_rd = 1'b1;
                inst_d.load  = 1'b1;
            end
            S_X_L0: begin
                if (cnt_d < CNT_W'(len_nij)) begin
                    inst_d.cen_xmem = 1'b0;
                    inst_d.a_xmem   = 11'(cnt_d);
                end
                inst_d.l0_wr = (cnt_d != '0);
            end
            S_EXEC: begin
                inst_d.l0_rd   = 1'b1;
                inst_d.execute = 1'b1;
            end
            S_OFIFO: begin
                inst_d.ofifo_rd = rd_d;
                if (wr_d) begin
                    inst_d.cen_pmem = 1'b0;
                    inst_d.wen_pmem = 1'b0;
                    inst_d.a_pmem   = 11'(kij_q) * 11'(len_nij) + 11'(wr_cnt_q);
                end
            end
            default: ;
        endcase
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
